// File: rtl/inst_fetch_unit.sv
// Fetch stage and IF/ID register for the RV64IF core.
// Single-outstanding imem requests, one-entry skid buffer, immediate-format pre-decode.
module inst_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            in_clk,
  input  logic            in_rst,
  output logic            out_imem_req,
  output logic [XLEN-1:0] out_imem_addr,
  input  logic            in_imem_ack,
  input  logic [31:0]     in_imem_data,
  input  logic            in_stall,
  input  logic            in_redirect,
  input  logic [XLEN-1:0] in_redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [2:0]      out_inst_type
);

  typedef enum logic [1:0] {
    FETCH,
    BUFFERED,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [2:0]      ty;
  } entry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [2:0] imm_type(input logic [6:0] op);
    logic [2:0] t;
    unique case (op)
      7'b0000011, 7'b0000111, 7'b0001111, 7'b0010011,
      7'b0011011, 7'b1100111, 7'b1110011: t = 3'b000;
      7'b0110111, 7'b0010111:             t = 3'b001;
      7'b1101111:                         t = 3'b011;
      7'b1100011:                         t = 3'b100;
      7'b0100011, 7'b0100111:             t = 3'b101;
      default:                            t = 3'b111;
    endcase
    return t;
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  entry_t          ifid_q, ifid_d;
  logic            valid_q, valid_d;
  entry_t          skid_q, skid_d;
  logic            skid_v_q, skid_v_d;

  logic            req;
  logic            ack;
  logic            can_load;
  entry_t          mem_e;

  assign req      = !in_rst && (state_q != BUFFERED);
  assign ack      = req && in_imem_ack;
  assign can_load = !valid_q || !in_stall;
  assign mem_e    = '{pc: pc_q, inst: in_imem_data,
                      ty: imm_type(in_imem_data[6:0])};

  // DRAIN keeps presenting the abandoned address; pc_q already holds the target
  assign out_imem_req  = req;
  assign out_imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign out_valid     = valid_q;
  assign out_pc        = ifid_q.pc;
  assign out_inst      = ifid_q.inst;
  assign out_inst_type = ifid_q.ty;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    ifid_d       = ifid_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    skid_v_d     = skid_v_q;
    if (in_redirect) begin
      pc_d         = in_redirect_pc;
      valid_d      = 1'b0;
      skid_v_d     = 1'b0;
      drain_addr_d = out_imem_addr;
      state_d      = (req && !in_imem_ack) ? DRAIN : FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack) begin
            pc_d = pc_q + XLEN'(4);
            if (can_load) begin
              ifid_d  = mem_e;
              valid_d = 1'b1;
            end else begin
              skid_d   = mem_e;
              skid_v_d = 1'b1;
              state_d  = BUFFERED;
            end
          end else if (can_load) begin
            valid_d = 1'b0;
          end
        end
        BUFFERED: begin
          if (!in_stall) begin
            ifid_d   = skid_q;
            valid_d  = 1'b1;
            skid_v_d = 1'b0;
            state_d  = FETCH;
          end
        end
        DRAIN: begin
          if (ack) state_d = FETCH;
          if (can_load) valid_d = 1'b0;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      ifid_q       <= '{pc: '0, inst: NOP, ty: 3'b111};
      valid_q      <= 1'b0;
      skid_q       <= '0;
      skid_v_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      ifid_q       <= ifid_d;
      valid_q      <= valid_d;
      skid_q       <= skid_d;
      skid_v_q     <= skid_v_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed-vector bench for inst_fetch_unit.
// Memory is either a zero-latency ROM (auto) or hand-driven acks.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [63:0] addr;
  logic        ack;
  logic [31:0] data;
  logic        stall;
  logic        redir;
  logic [63:0] redir_pc;
  logic        valid;
  logic [63:0] pc;
  logic [31:0] inst;
  logic [2:0]  ity;

  logic        auto;
  logic        man_ack;
  logic [31:0] man_data;

  logic [31:0] rom [8];
  logic [2:0]  rty [8];
  logic [6:0]  ops [10];
  logic [2:0]  oty [10];

  int vec;
  int errs;

  always #5 clk = ~clk;

  assign ack  = auto ? req : man_ack;
  assign data = auto ? rom[addr[4:2]] : man_data;

  inst_fetch_unit #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .out_imem_req  (req),
    .out_imem_addr (addr),
    .in_imem_ack   (ack),
    .in_imem_data  (data),
    .in_stall      (stall),
    .in_redirect   (redir),
    .in_redirect_pc(redir_pc),
    .out_valid     (valid),
    .out_pc        (pc),
    .out_inst      (inst),
    .out_inst_type (ity)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    vec++;
    if (req !== 1'b0) begin
      errs++; $display("FAIL rst_req got %b exp 0", req);
    end
    vec++;
    if (valid !== 1'b0) begin
      errs++; $display("FAIL rst_valid got %b exp 0", valid);
    end
    vec++;
    if (pc !== 64'h0) begin
      errs++; $display("FAIL rst_pc got %h exp 0", pc);
    end
    vec++;
    if (inst !== 32'h13) begin
      errs++; $display("FAIL rst_inst got %h exp 00000013", inst);
    end
    vec++;
    if (ity !== 3'b111) begin
      errs++; $display("FAIL rst_type got %b exp 111", ity);
    end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    #1;
    vec++;
    if (req !== 1'b1 || addr !== 64'h0) begin
      errs++; $display("FAIL first_req got %b/%h exp 1/0", req, addr);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      vec++;
      if (valid !== 1'b1 || pc !== 64'(4 * k)) begin
        errs++;
        $display("FAIL stream_pc[%0d] got %b/%h exp 1/%h", k, valid, pc, 4 * k);
      end
      vec++;
      if (inst !== rom[k] || ity !== rty[k]) begin
        errs++;
        $display("FAIL stream_inst[%0d] got %h/%b exp %h/%b",
                 k, inst, ity, rom[k], rty[k]);
      end
      vec++;
      if (addr !== 64'(4 * k + 4)) begin
        errs++; $display("FAIL stream_addr[%0d] got %h exp %h", k, addr, 4 * k + 4);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_stall_skid();
    auto = 1'b1;
    do_reset();
    repeat (3) step();
    vec++;
    if (pc !== 64'h8 || addr !== 64'hc) begin
      errs++; $display("FAIL stall_setup got %h/%h exp 8/c", pc, addr);
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vec++;
      if (req !== 1'b0 || pc !== 64'h8 || valid !== 1'b1) begin
        errs++;
        $display("FAIL stall_hold[%0d] got req=%b pc=%h v=%b exp 0/8/1",
                 k, req, pc, valid);
      end
    end
    stall = 1'b0;
    step();
    vec++;
    if (pc !== 64'hc || inst !== rom[3] || ity !== 3'b100) begin
      errs++; $display("FAIL skid_out got %h/%h/%b exp c/%h/100", pc, inst, ity, rom[3]);
    end
    vec++;
    if (req !== 1'b1 || addr !== 64'h10) begin
      errs++; $display("FAIL skid_resume got %b/%h exp 1/10", req, addr);
    end
    step();
    vec++;
    if (pc !== 64'h10 || inst !== rom[4]) begin
      errs++; $display("FAIL after_skid got %h/%h exp 10/%h", pc, inst, rom[4]);
    end
  endtask

  task automatic test_redirect_drain();
    auto    = 1'b0;
    man_ack = 1'b0;
    do_reset();
    vec++;
    if (req !== 1'b1 || addr !== 64'h0) begin
      errs++; $display("FAIL drain_req0 got %b/%h exp 1/0", req, addr);
    end
    step();
    redir    = 1'b1;
    redir_pc = 64'h100;
    step();
    redir = 1'b0;
    #1;
    vec++;
    if (req !== 1'b1 || addr !== 64'h0 || valid !== 1'b0) begin
      errs++; $display("FAIL drain_hold got %b/%h/%b exp 1/0/0", req, addr, valid);
    end
    man_ack  = 1'b1;
    man_data = rom[2];
    step();
    man_ack = 1'b0;
    #1;
    vec++;
    if (req !== 1'b1 || addr !== 64'h100) begin
      errs++; $display("FAIL drain_next got %b/%h exp 1/100", req, addr);
    end
    vec++;
    if (valid !== 1'b0 || inst !== 32'h13) begin
      errs++; $display("FAIL drain_discard got %b/%h exp 0/00000013", valid, inst);
    end
  endtask

  task automatic test_redirect_ack();
    man_ack  = 1'b1;
    man_data = rom[2];
    redir    = 1'b1;
    redir_pc = 64'h200;
    step();
    redir   = 1'b0;
    man_ack = 1'b0;
    #1;
    vec++;
    if (req !== 1'b1 || addr !== 64'h200 || valid !== 1'b0) begin
      errs++; $display("FAIL redir_ack got %b/%h/%b exp 1/200/0", req, addr, valid);
    end
    vec++;
    if (inst !== 32'h13) begin
      errs++; $display("FAIL redir_ack_inst got %h exp 00000013", inst);
    end
    man_ack  = 1'b1;
    man_data = rom[0];
    step();
    man_ack = 1'b0;
    #1;
    vec++;
    if (valid !== 1'b1 || pc !== 64'h200 || inst !== rom[0] || ity !== 3'b000) begin
      errs++;
      $display("FAIL no_drain got %b/%h/%h/%b exp 1/200/%h/000", valid, pc, inst, ity, rom[0]);
    end
    vec++;
    if (addr !== 64'h204) begin
      errs++; $display("FAIL no_drain_addr got %h exp 204", addr);
    end
  endtask

  task automatic test_reset_buffered();
    auto  = 1'b1;
    stall = 1'b1;
    step();
    vec++;
    if (req !== 1'b0 || pc !== 64'h200 || valid !== 1'b1) begin
      errs++; $display("FAIL buf_setup got %b/%h/%b exp 0/200/1", req, pc, valid);
    end
    rst = 1'b1;
    step();
    vec++;
    if (valid !== 1'b0 || inst !== 32'h13 || ity !== 3'b111 || req !== 1'b0) begin
      errs++;
      $display("FAIL mid_rst got v=%b i=%h t=%b r=%b exp 0/00000013/111/0",
               valid, inst, ity, req);
    end
    rst   = 1'b0;
    stall = 1'b0;
    #1;
    vec++;
    if (req !== 1'b1 || addr !== 64'h0) begin
      errs++; $display("FAIL mid_rst_req got %b/%h exp 1/0", req, addr);
    end
    step();
    vec++;
    if (valid !== 1'b1 || pc !== 64'h0 || inst !== rom[0]) begin
      errs++; $display("FAIL mid_rst_skid got %b/%h/%h exp 1/0/%h", valid, pc, inst, rom[0]);
    end
  endtask

  task automatic test_wrap();
    redir    = 1'b1;
    redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redir = 1'b0;
    #1;
    vec++;
    if (addr !== 64'hFFFF_FFFF_FFFF_FFFC || valid !== 1'b0) begin
      errs++; $display("FAIL wrap_addr got %h/%b exp fffffffffffffffc/0", addr, valid);
    end
    step();
    vec++;
    if (pc !== 64'hFFFF_FFFF_FFFF_FFFC || inst !== rom[7] || ity !== 3'b001) begin
      errs++; $display("FAIL wrap_pc got %h/%h/%b exp ..fffc/%h/001", pc, inst, ity, rom[7]);
    end
    vec++;
    if (addr !== 64'h0) begin
      errs++; $display("FAIL wrap_next got %h exp 0", addr);
    end
  endtask

  task automatic test_decode();
    auto    = 1'b0;
    man_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      man_data = {25'h0, ops[i]};
      step();
      vec++;
      if (valid !== 1'b1 || ity !== oty[i]) begin
        errs++;
        $display("FAIL decode[%b] got %b/%b exp 1/%b", ops[i], valid, ity, oty[i]);
      end
    end
    man_ack = 1'b0;
  endtask

  initial begin
    vec      = 0;
    errs     = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    redir    = 1'b0;
    redir_pc = 64'h0;
    auto     = 1'b1;
    man_ack  = 1'b0;
    man_data = 32'h0;
    rom[0] = 32'h0010_0093; rty[0] = 3'b000;
    rom[1] = 32'h0000_10b7; rty[1] = 3'b001;
    rom[2] = 32'h0080_006f; rty[2] = 3'b011;
    rom[3] = 32'h0000_0463; rty[3] = 3'b100;
    rom[4] = 32'h0011_2023; rty[4] = 3'b101;
    rom[5] = 32'h0020_81b3; rty[5] = 3'b111;
    rom[6] = 32'h0000_a103; rty[6] = 3'b000;
    rom[7] = 32'h0000_0117; rty[7] = 3'b001;
    ops[0] = 7'b0000111; oty[0] = 3'b000;
    ops[1] = 7'b0001111; oty[1] = 3'b000;
    ops[2] = 7'b0011011; oty[2] = 3'b000;
    ops[3] = 7'b1100111; oty[3] = 3'b000;
    ops[4] = 7'b1110011; oty[4] = 3'b000;
    ops[5] = 7'b0100111; oty[5] = 3'b101;
    ops[6] = 7'b1010011; oty[6] = 3'b111;
    ops[7] = 7'b1000011; oty[7] = 3'b111;
    ops[8] = 7'b0000000; oty[8] = 3'b111;
    ops[9] = 7'b0111011; oty[9] = 3'b111;
    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect_drain();
    test_redirect_ack();
    test_reset_buffered();
    test_wrap();
    test_decode();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
